// File: rtl/simple_adder.sv
// Registered WIDTH-bit adder with one-cycle latency, valid qualifier and
// carry / signed-overflow / zero flags.
module simple_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   full_sum;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             carry_reg, carry_next;
    logic             overflow_reg, overflow_next;
    logic             zero_reg, zero_next;
    logic             out_valid_reg;

    assign full_sum = {1'b0, a} + {1'b0, b};

    // Flags follow the freshly computed sum; when in_valid is low the
    // registers recirculate, so unknown operands never reach the outputs.
    always_comb begin
        result_next   = result_reg;
        carry_next    = carry_reg;
        overflow_next = overflow_reg;
        zero_next     = zero_reg;
        if (in_valid) begin
            result_next   = full_sum[WIDTH-1:0];
            carry_next    = full_sum[WIDTH];
            overflow_next = (a[MSB] == b[MSB]) && (full_sum[MSB] != a[MSB]);
            zero_next     = (full_sum[WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            result_reg    <= result_next;
            carry_reg     <= carry_next;
            overflow_reg  <= overflow_next;
            zero_reg      <= zero_next;
            out_valid_reg <= in_valid;
        end
    end

    assign result    = result_reg;
    assign carry     = carry_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_simple_adder.sv
// Self-checking bench for simple_adder: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_simple_adder;

    localparam int W = 4;
    localparam int MOD = 1 << W;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_valid = 1'b0;
    logic [W-1:0] result;
    logic         carry, overflow, zero, out_valid;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: what the outputs must show after the latest rising edge.
    int m_result = 0;
    bit m_carry = 0, m_overflow = 0, m_zero = 0, m_valid = 0;
    int ia, ib, sa, sb, usum, ssum;

    simple_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_result = 0; m_carry = 0; m_overflow = 0; m_zero = 0; m_valid = 0;
        end else if (in_valid) begin
            ia = int'(a);
            ib = int'(b);
            usum = ia + ib;
            sa = (ia > SMAX) ? ia - MOD : ia;
            sb = (ib > SMAX) ? ib - MOD : ib;
            ssum = sa + sb;
            m_result   = usum % MOD;
            m_carry    = (usum >= MOD);
            m_overflow = (ssum > SMAX) || (ssum < SMIN);
            m_zero     = (m_result == 0);
            m_valid    = 1;
        end else begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (result !== W'(m_result) || carry !== m_carry || overflow !== m_overflow ||
                zero !== m_zero || out_valid !== m_valid) begin
                errors++;
                $display("FAIL model t=%0t got r=%0d c=%0b o=%0b z=%0b v=%0b expected r=%0d c=%0b o=%0b z=%0b v=%0b",
                         $time, result, carry, overflow, zero, out_valid,
                         m_result, m_carry, m_overflow, m_zero, m_valid);
            end
        end
    end

    task automatic cycle(input bit rn, input bit v, input logic [W-1:0] aa, input logic [W-1:0] bb);
        @(negedge clk);
        #1;
        rst_n = rn;
        in_valid = v;
        a = aa;
        b = bb;
        @(posedge clk);
        #1;
        $display("txn rst_n=%0b in_valid=%0b a=%0d b=%0d -> result=%0d c=%0b o=%0b z=%0b v=%0b",
                 rn, v, aa, bb, result, carry, overflow, zero, out_valid);
    endtask

    task automatic expect_lit(input string name, input logic [W-1:0] r, input bit c,
                              input bit o, input bit z, input bit v);
        checks++;
        if (result !== r || carry !== c || overflow !== o || zero !== z || out_valid !== v) begin
            errors++;
            $display("FAIL %s got r=%0d c=%0b o=%0b z=%0b v=%0b expected r=%0d c=%0b o=%0b z=%0b v=%0b",
                     name, result, carry, overflow, zero, out_valid, r, c, o, z, v);
        end
    endtask

    initial begin
        cycle(0, 1, 4'hF, 4'hF);
        cycle(0, 1, 4'hF, 4'hF);
        chk_en = 1'b1;
        expect_lit("reset", 4'h0, 0, 0, 0, 0);
        cycle(1, 1, 4'hF, 4'hF);
        expect_lit("release_15p15", 4'hE, 1, 0, 0, 1);
        cycle(1, 1, 4'h4, 4'h2);
        expect_lit("4p2", 4'h6, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 4'hF, 4'hF);
            expect_lit("hold", 4'h6, 0, 0, 0, 0);
        end
        cycle(1, 1, 4'h6, 4'hA);
        expect_lit("6p10_wrap", 4'h0, 1, 0, 1, 1);
        cycle(1, 1, 4'h7, 4'h1);
        expect_lit("7p1_ovf", 4'h8, 0, 1, 0, 1);
        cycle(1, 1, 4'h8, 4'h8);
        expect_lit("8p8_ovf", 4'h0, 1, 1, 1, 1);
        cycle(1, 1, 4'h1, 4'h1);
        expect_lit("stream0", 4'h2, 0, 0, 0, 1);
        cycle(1, 1, 4'h2, 4'h3);
        expect_lit("stream1", 4'h5, 0, 0, 0, 1);
        cycle(1, 1, 4'hF, 4'h1);
        expect_lit("stream2", 4'h0, 1, 0, 1, 1);
        cycle(1, 1, 4'h8, 4'h7);
        expect_lit("stream3", 4'hF, 0, 0, 0, 1);
        cycle(1, 1, 4'h3, 4'h4);
        expect_lit("pre_abort", 4'h7, 0, 0, 0, 1);
        cycle(0, 1, 4'h5, 4'h5);
        expect_lit("abort_reset", 4'h0, 0, 0, 0, 0);
        cycle(1, 0, 4'h5, 4'h5);
        expect_lit("after_abort", 4'h0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7),
                  W'($urandom), W'($urandom));
        end

        cycle(1, 0, 4'h0, 4'h0);
        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
